// File: rtl/tt_um_bouncing_box.sv
// 640x480@60 VGA bouncing-box demo for a TinyTapeout tile, TinyVGA Pmod pinout on uo_out.
// Optional BOUNCE_COLOR_CYCLE_EN: box colour comes from an internal register that advances on every bounce.
module tt_um_bouncing_box (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   localparam logic [9:0]  H_VISIBLE    = 10'd640;
   localparam logic [9:0]  H_SYNC_START = 10'd656;
   localparam logic [9:0]  H_SYNC_END   = 10'd752;
   localparam logic [9:0]  H_LAST       = 10'd799;
   localparam logic [9:0]  V_VISIBLE    = 10'd480;
   localparam logic [9:0]  V_SYNC_START = 10'd490;
   localparam logic [9:0]  V_SYNC_END   = 10'd492;
   localparam logic [9:0]  V_LAST       = 10'd524;
   localparam logic [10:0] BOX_SIZE     = 11'd32;
   localparam logic [10:0] X_MAX        = 11'd608;
   localparam logic [10:0] Y_MAX        = 11'd448;
   localparam logic [10:0] X_RESET      = 11'd64;
   localparam logic [10:0] Y_RESET      = 11'd48;

   logic [9:0]  hcount_q, hcount_d;
   logic [9:0]  vcount_q, vcount_d;
   logic [10:0] x_q, x_d, y_q, y_d;
   logic        dx_q, dx_d, dy_q, dy_d;
   logic [7:0]  uo_q, uo_d;
   logic        update;
   logic        flip;
   logic [10:0] step;
   logic [10:0] hpos, vpos;
   logic        visible, in_box;
   logic        hsync_n, vsync_n;
   logic [2:0]  box_colour;
   logic [2:0]  rgb;
   logic        unused_inputs;

   // Returns {new_direction, new_position}; 11-bit math keeps pos+step from wrapping.
   function automatic logic [11:0] bounce(input logic [10:0] pos, input logic dir,
                                          input logic [10:0] s, input logic [10:0] lim);
      logic [11:0] res;
      if (dir) begin
         if (pos + s >= lim) res = {1'b0, lim};
         else                res = {1'b1, pos + s};
      end else begin
         if (pos <= s) res = {1'b1, 11'd0};
         else          res = {1'b0, pos - s};
      end
      return res;
   endfunction

   always_comb begin
      hcount_d = hcount_q + 10'd1;
      vcount_d = vcount_q;
      if (hcount_q == H_LAST) begin
         hcount_d = '0;
         vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 10'd1;
      end
   end

   // Motion is committed inside vertical blanking so a frame never shows a torn box.
   assign update = (hcount_q == '0) && (vcount_q == V_VISIBLE) && !ui_in[0];
   assign step   = {9'd0, ui_in[2:1]} + 11'd1;

   always_comb begin
      x_d  = x_q;
      dx_d = dx_q;
      y_d  = y_q;
      dy_d = dy_q;
      if (update) begin
         {dx_d, x_d} = bounce(x_q, dx_q, step, X_MAX);
         {dy_d, y_d} = bounce(y_q, dy_q, step, Y_MAX);
      end
   end

   assign flip = update && ((dx_d != dx_q) || (dy_d != dy_q));

`ifdef BOUNCE_COLOR_CYCLE_EN
   logic [2:0] colour_q, colour_d;

   always_comb begin
      colour_d = colour_q;
      if (flip) colour_d = (colour_q == 3'b111) ? 3'b001 : colour_q + 3'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) colour_q <= 3'b111;
      else        colour_q <= colour_d;
   end

   assign box_colour = colour_q;
`else
   assign box_colour = ui_in[7:5];
`endif

   assign hpos    = {1'b0, hcount_q};
   assign vpos    = {1'b0, vcount_q};
   assign visible = (hcount_q < H_VISIBLE) && (vcount_q < V_VISIBLE);
   assign in_box  = visible &&
                    (hpos >= x_q) && (hpos < x_q + BOX_SIZE) &&
                    (vpos >= y_q) && (vpos < y_q + BOX_SIZE);
   assign hsync_n = !((hcount_q >= H_SYNC_START) && (hcount_q < H_SYNC_END));
   assign vsync_n = !((vcount_q >= V_SYNC_START) && (vcount_q < V_SYNC_END));
   assign rgb     = in_box ? box_colour : 3'b000;

   always_comb begin
      uo_d = {hsync_n, rgb[0], rgb[1], rgb[2], vsync_n, rgb[0], rgb[1], rgb[2]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hcount_q <= '0;
         vcount_q <= '0;
         x_q      <= X_RESET;
         y_q      <= Y_RESET;
         dx_q     <= 1'b1;
         dy_q     <= 1'b1;
         uo_q     <= 8'h88;
      end else begin
         hcount_q <= hcount_d;
         vcount_q <= vcount_d;
         x_q      <= x_d;
         y_q      <= y_d;
         dx_q     <= dx_d;
         dy_q     <= dy_d;
         uo_q     <= uo_d;
      end
   end

   assign uo_out  = uo_q;
   assign uio_out = '0;
   assign uio_oe  = '0;

   assign unused_inputs = ^{ena, uio_in, ui_in, flip};

endmodule

// File: tb/tb_tt_um_bouncing_box.sv
// Scoreboard bench for tt_um_bouncing_box: stimulus queues expected outputs by cycle, a monitor compares.
// Counters are repositioned by force so whole frames need not be simulated.
module tb_tt_um_bouncing_box;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uo_out;
   logic [7:0] uio_in;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   always #20 clk = ~clk;

   tt_um_bouncing_box dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .uo_out  (uo_out),
      .uio_in  (uio_in),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   typedef struct {
      int unsigned cyc;
      logic [23:0] mask;
      logic [23:0] val;
      string       name;
   } exp_t;

   exp_t        sb[$];
   int unsigned cyc = 0;
   int unsigned n_tests = 0;
   int unsigned n_fail = 0;
   bit          drain_timeout = 1'b0;
   bit          timeout_counted = 1'b0;
   logic [2:0]  col_reg;
   logic [9:0]  frc_h, frc_v;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin : monitor
      exp_t        e;
      logic [23:0] obs;
      obs = {uio_oe, uio_out, uo_out};
      if (drain_timeout && !timeout_counted) begin
         timeout_counted = 1'b1;
         n_tests++;
         n_fail++;
         $display("FAIL drain: %0d expectations still pending, required 0", sb.size());
      end
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         e = sb.pop_front();
         n_tests++;
         if (e.cyc != cyc) begin
            n_fail++;
            $display("FAIL %s: sampled at cycle %0d, required cycle %0d", e.name, cyc, e.cyc);
         end else if ((obs & e.mask) !== e.val) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (mask %h)", e.name, obs & e.mask, e.val, e.mask);
         end
      end
   end

   task automatic expect_uo(input int unsigned n, input logic [7:0] v, input string name);
      exp_t e;
      e.cyc  = cyc + n;
      e.mask = 24'hFFFFFF;
      e.val  = {16'h0000, v};
      e.name = name;
      sb.push_back(e);
   endtask

   task automatic expect_bits(input int unsigned n, input logic [7:0] m, input logic [7:0] v,
                              input string name);
      exp_t e;
      e.cyc  = cyc + n;
      e.mask = {16'h0000, m};
      e.val  = {16'h0000, v};
      e.name = name;
      sb.push_back(e);
   endtask

   function automatic logic [7:0] pix(input logic [2:0] c);
      return {1'b1, c[0], c[1], c[2], 1'b1, c[0], c[1], c[2]};
   endfunction

   function automatic logic [2:0] box_col();
`ifdef BOUNCE_COLOR_CYCLE_EN
      return col_reg;
`else
      return ui_in[7:5];
`endif
   endfunction

   task automatic col_bump();
      col_reg = (col_reg == 3'b111) ? 3'b001 : col_reg + 3'd1;
   endtask

   // Called at a negedge; returns just after the following negedge with the counters at (h, v).
   task goto(input int v, input int h);
      frc_h = (h == 0) ? 10'd799 : 10'(h - 1);
      frc_v = (h != 0) ? 10'(v) : ((v == 0) ? 10'd524 : 10'(v - 1));
      force dut.hcount_q = frc_h;
      force dut.vcount_q = frc_v;
      @(negedge clk);
      frc_h = 10'(h);
      frc_v = 10'(v);
      force dut.hcount_q = frc_h;
      force dut.vcount_q = frc_v;
      #1;
      release dut.hcount_q;
      release dut.vcount_q;
   endtask

   task do_updates(input int n);
      for (int i = 0; i < n; i++) begin
         goto(480, 0);
         @(negedge clk);
      end
   endtask

   task check_box(input int x, input int y, input string tag);
      logic [7:0] c;
      c = pix(box_col());
      goto(y, x - 1);
      expect_uo(1,  8'h88, {tag, " left of box"});
      expect_uo(2,  c,     {tag, " top-left"});
      expect_uo(33, c,     {tag, " top-right"});
      expect_uo(34, 8'h88, {tag, " right of box"});
      repeat (35) @(negedge clk);
      if (y > 0) begin
         goto(y - 1, x);
         expect_uo(1, 8'h88, {tag, " above box"});
         repeat (2) @(negedge clk);
      end
      goto(y + 31, x);
      expect_uo(1, c, {tag, " bottom-left"});
      repeat (2) @(negedge clk);
   endtask

   initial begin
      rst_n   = 1'b0;
      ena     = 1'b1;
      ui_in   = 8'hE0;
      uio_in  = 8'hA5;
      col_reg = 3'b111;
      frc_h   = '0;
      frc_v   = '0;

      repeat (10) @(negedge clk);
      expect_uo(1, 8'h88, "reset value");
      @(negedge clk);
      rst_n = 1'b1;
      expect_uo(1, 8'h88, "first clock after release");
      expect_bits(656,  8'h80, 8'h80, "hsync high before fall");
      expect_bits(657,  8'h80, 8'h00, "hsync fall");
      expect_bits(752,  8'h80, 8'h00, "hsync last low");
      expect_bits(753,  8'h80, 8'h80, "hsync rise");
      expect_bits(1456, 8'h80, 8'h80, "hsync high line1");
      expect_bits(1457, 8'h80, 8'h00, "hsync fall line1");
      repeat (1460) @(negedge clk);

      check_box(64, 48, "frame0");
      do_updates(1);
      check_box(65, 49, "frame1 s1");

      ui_in = 8'hE1;
      do_updates(3);
      check_box(65, 49, "paused");

      ui_in = 8'hA6;
      do_updates(100);
      col_bump();
      check_box(465, 448, "y hits max");
      do_updates(1);
      check_box(469, 444, "y reflects down");
      do_updates(35);
      col_bump();
      check_box(608, 304, "x hits max");
      do_updates(1);
      check_box(604, 300, "x reflects left");
      ui_in = 8'h46;
      do_updates(75);
      col_bump();
      check_box(304, 0, "y hits zero");
      do_updates(1);
      check_box(300, 4, "y reflects up");

      goto(489, 798);
      expect_uo(1,    8'h88, "before vsync");
      expect_uo(3,    8'h80, "vsync fall line490");
      expect_uo(659,  8'h00, "both syncs low");
      expect_uo(1602, 8'h80, "vsync last low");
      expect_uo(1603, 8'h88, "vsync rise line492");
      repeat (1605) @(negedge clk);

      goto(100, 700);
      expect_uo(1, 8'h08, "hsync mid-frame");
      @(negedge clk);
      expect_uo(1, 8'h88, "async reset");
      #25 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n   = 1'b1;
      col_reg = 3'b111;
      expect_bits(656, 8'h80, 8'h80, "hsync high after re-reset");
      expect_bits(657, 8'h80, 8'h00, "hsync fall after re-reset");
      repeat (660) @(negedge clk);
      check_box(64, 48, "position after reset");

      for (int i = 0; i < 2000 && sb.size() > 0; i++) @(negedge clk);
      if (sb.size() > 0) drain_timeout = 1'b1;
      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/tt_um_bouncing_box.md
# tt_um_bouncing_box

VGA demo top level for a TinyTapeout tile. It generates 640×480 @ 60 Hz timing from a 25.175 MHz (nominally 25 MHz) pixel clock and draws a 32×32 solid box on a black background. The box bounces off the four screen edges. Output goes through the dedicated outputs in TinyVGA Pmod pinout, and the bidirectional pins are unused.

## Interface
- No parameters; geometry constants are fixed: box size 32, screen 640×480.
- clk  in  1  pixel clock, 25 MHz nominal.
- rst_n  in  1  reset; one clock, reset asynchronous and active-low.
- ena  in  1  tile enable; ignored.
- ui_in  in  8  controls:
  - [0] pause, 1 = freeze motion.
  - [2:1] speed code; step = code+1 px/frame.
  - [4:3] reserved.
  - [7:5] box colour {R,G,B}.
- uo_out  out  8  TinyVGA:
  - [0] R1, [1] G1, [2] B1, [3] vsync.
  - [4] R0, [5] G0, [6] B0, [7] hsync.
- uio_in  in  8  ignored.
- uio_out  out  8  constant 0.
- uio_oe  out  8  constant 0 (all inputs).

## Operation
- hcount 0..799 increments every clock and wraps to 0.
- vcount 0..524 increments when hcount wraps, and itself wraps to 0 after 524.
- Horizontal: visible 0–639, front porch 640–655, sync 656–751, back porch 752–799.
- Vertical: visible 0–479, front porch 480–489, sync 490–491, back porch 492–524.
- hsync and vsync are active low.
- Box state:
  - x in 0..608, y in 0..448 (top-left corner).
  - Direction flags dx, dy (1 = increasing).
  - Reset values: x=64, y=48, dx=dy=1.
- Position update happens once per frame, on the clock where hcount=0 and vcount=480, only if ui_in[0]=0.
- Step per update is s = ui_in[2:1]+1. Per axis:
  - If moving positive and pos+s ≥ max (608 for x, 448 for y): pos=max and flag flips to negative.
  - If moving negative and pos ≤ s: pos=0 and flag flips to positive.
  - Otherwise pos ± s.
  - Use 11-bit arithmetic so no wrap-around is possible.
- Corner hits flip both flags in the same update.
- Pixel is inside the box when the pixel is visible, x ≤ hcount < x+32 and y ≤ vcount < y+32.
- Inside the box, each colour channel outputs both bits = the corresponding colour bit. Everywhere else, and during blanking, RGB = 0.
- All uo_out bits are registered.

## Timing
- uo_out lags its counter value by exactly 1 clock.
- Reset value of uo_out is 8'h88 (syncs high, colour 0). This value holds through the first clock after release.
- Line period is 800 clocks, frame period 420 000 clocks.
- hsync is low for 96 clocks per line; vsync is low for 1600 clocks per frame.
- A position change becomes visible starting with the next frame's line 0. Because the update falls in vertical blanking, no frame ever shows a torn box.
- Changes to ui_in take effect combinationally for colour, delayed by the output register. Speed and pause are sampled only at the update clock.
- If reset is asserted mid-frame, counters, position, flags and outputs return immediately to their reset values.

## Configuration
- Macro: BOUNCE_COLOR_CYCLE_EN.
- Defined:
  - A 3-bit colour register resets to 3'b111 and sets the box colour; ui_in[7:5] is ignored.
  - On every update where at least one flag flips (a corner hit counts once), the register increments, skipping 3'b000 (111 → 001).
- Undefined: box colour = ui_in[7:5] directly.

## Test plan
- Reset with rst_n low for 10 clocks → uo_out=8'h88, uio_out=0, uio_oe=0.
- Run 2 lines → hsync falls 657 clocks after reset release and is low for exactly 96 clocks; the falling edge repeats every 800 clocks.
- Run 1 frame → vsync is low for 1600 clocks starting at line 490, and the falling edge repeats every 420 000 clocks.
- ui_in=8'hE0 (white, speed 1), first frame → pixel (64,48) gives RGB bits all 1, pixel (96,48) gives black. In frame 2 the box's top-left is at (65,49).
- ui_in speed=3 (s=4), box forced by running ≥150 frames → x reaches 608, then next update x=604 with dx=0. The y axis bounces at 448 the same way, and at 0 it reflects back upward.
- ui_in[0]=1 for 3 frames → box position is identical across all 3 frames. With BOUNCE_COLOR_CYCLE_EN defined, the colour advances 111 → 001 on the first bounce.
